// File: rtl/osc_pkg.sv
// Shared types and defaults for the oscilloscope capture path.
package osc_pkg;

  localparam int unsigned DEPTH_DEF = 10000;
  localparam int unsigned AW_DEF    = 14;
  localparam int unsigned SAMPLE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_ARMED,
    ST_POSTTRIG,
    ST_WAIT_PI
  } cap_state_e;

endpackage

// File: rtl/trig_detect.sv
// Slope trigger on consecutive written samples, plus a held force request.
module trig_detect
  import osc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic                armed,
  input  logic                sample_valid,
  input  logic                force_trig,
  input  logic                rising,
  input  logic [SAMPLE_W-1:0] level,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                fire
);

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                pend_q, pend_d;
  logic                slope_hit;

  always_comb begin
    slope_hit = rising ? ((prev_q < level) && (sample >= level))
                       : ((prev_q > level) && (sample <= level));
    fire = armed && sample_valid && (pend_q || force_trig || (prev_valid_q && slope_hit));

    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (clr) begin
      prev_valid_d = 1'b0;
    end else if (load) begin
      prev_d       = sample;
      prev_valid_d = 1'b1;
    end

    // A force request waits for the next sample; it is dropped once ARMED is left.
    pend_d = armed && !fire && (pend_q || force_trig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      pend_q       <= pend_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, trigger wait, post-trigger fill, Pi handoff.
module capture_ctrl
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                osc_clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                force_trig,
  input  logic                trig_rising,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [AW-1:0]       pre_len,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                pi_ack,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                frame_ready,
  output logic [AW-1:0]       frame_start,
  output logic [AW-1:0]       trig_addr,
  output logic                busy
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [AW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [AW-1:0]       pre_len_q, pre_len_d;
  logic [AW-1:0]       trig_addr_q, trig_addr_d;
  logic [AW-1:0]       frame_start_q, frame_start_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       pre_len_clamp;
  logic [AW:0]         start_diff;
  logic                capturing, do_write, restart, trig_hit, armed;

  assign armed = (state_q == ST_ARMED);

  trig_detect u_trig (
    .clk          (osc_clk),
    .rst_n        (reset),
    .clr          (restart),
    .load         (do_write),
    .armed        (armed),
    .sample_valid (sample_valid),
    .force_trig   (force_trig),
    .rising       (trig_rising),
    .level        (trig_level),
    .sample       (sample),
    .fire         (trig_hit)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    pre_len_d     = pre_len_q;
    trig_addr_d   = trig_addr_q;
    frame_start_d = frame_start_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    restart       = 1'b0;

    pre_len_clamp = ({1'b0, pre_len} >= DEPTH_X) ? LAST : pre_len;
    // Extra bit keeps the borrow visible so the wrap adds DEPTH, not 2**AW.
    start_diff = {1'b0, ptr_q} - {1'b0, pre_len_q};
    if (start_diff[AW]) start_diff = start_diff + DEPTH_X;

    capturing = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POSTTRIG);
    do_write  = capturing && sample_valid;

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = sample;
      ptr_d     = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: if (arm) restart = 1'b1;
      ST_PRETRIG: begin
        if (sample_valid) pre_cnt_d = pre_cnt_q + AW'(1);
        if (!arm)                          state_d = ST_IDLE;
        else if (pre_cnt_q == pre_len_q)   state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (trig_hit) begin
          trig_addr_d   = ptr_q;
          frame_start_d = start_diff[AW-1:0];
          post_cnt_d    = LAST - pre_len_q;
          state_d       = (pre_len_q == LAST) ? ST_WAIT_PI : ST_POSTTRIG;
        end
      end
      ST_POSTTRIG: begin
        if (sample_valid) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = ST_WAIT_PI;
        end
      end
      ST_WAIT_PI: begin
        if (pi_ack) begin
          if (arm) restart = 1'b1;
          else     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d   = ST_PRETRIG;
      ptr_d     = '0;
      pre_cnt_d = '0;
      pre_len_d = pre_len_clamp;
    end
  end

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      pre_len_q     <= '0;
      trig_addr_q   <= '0;
      frame_start_q <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      pre_len_q     <= pre_len_d;
      trig_addr_q   <= trig_addr_d;
      frame_start_q <= frame_start_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign trig_addr   = trig_addr_q;
  assign frame_start = frame_start_q;
  assign frame_ready = (state_q == ST_WAIT_PI);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus random sessions against a sample-count model.
module tb_capture_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          osc_clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic          trig_rising = 1'b1;
  logic [7:0]    trig_level = 8'h80;
  logic [AW-1:0] pre_len = '0;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample = '0;
  logic          pi_ack = 1'b0;
  logic          wr_en, frame_ready, busy;
  logic [AW-1:0] wr_addr, frame_start, trig_addr;
  logic [7:0]    wr_data;

  int checks = 0;
  int errors = 0;

  capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .osc_clk      (osc_clk),
    .reset        (reset),
    .arm          (arm),
    .force_trig   (force_trig),
    .trig_rising  (trig_rising),
    .trig_level   (trig_level),
    .pre_len      (pre_len),
    .sample_valid (sample_valid),
    .sample       (sample),
    .pi_ack       (pi_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_ready  (frame_ready),
    .frame_start  (frame_start),
    .trig_addr    (trig_addr),
    .busy         (busy)
  );

  always #5 osc_clk = ~osc_clk;

  // Reference model: samples written since capture start, index of trigger sample.
  bit            active, done, pend, prev_ok;
  int            n, trig_n, pre_m;
  logic [7:0]    prev_m;
  logic          exp_wr_en;
  logic [AW-1:0] exp_wr_addr, exp_trig_addr, exp_frame_start;
  logic [7:0]    exp_wr_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit crosses(logic [7:0] p, logic [7:0] s);
    return trig_rising ? (p < trig_level && s >= trig_level)
                       : (p > trig_level && s <= trig_level);
  endfunction

  task automatic model_reset();
    active = 0; done = 0; pend = 0; prev_ok = 0; n = 0; trig_n = -1;
    exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0;
    exp_trig_addr = '0; exp_frame_start = '0;
  endtask

  task automatic restart_m();
    active = 1; done = 0; pend = 0; prev_ok = 0; n = 0; trig_n = -1;
    pre_m = (int'(pre_len) >= DEPTH) ? DEPTH - 1 : int'(pre_len);
  endtask

  task automatic model_edge(logic a, logic sv, logic [7:0] s, logic f, logic ack);
    exp_wr_en = 0;
    if (!active) begin
      if (a) restart_m();
    end else if (done) begin
      if (ack) begin
        if (a) restart_m();
        else   active = 0;
      end
    end else begin
      if (sv) begin
        exp_wr_en   = 1;
        exp_wr_addr = AW'(n % DEPTH);
        exp_wr_data = s;
        if (trig_n < 0 && a && n >= pre_m && (pend || (prev_ok && crosses(prev_m, s)))) begin
          trig_n          = n;
          exp_trig_addr   = AW'(n % DEPTH);
          exp_frame_start = AW'((n - pre_m + DEPTH) % DEPTH);
        end
        prev_m = s; prev_ok = 1; n++;
        if (trig_n >= 0 && n - trig_n == DEPTH - pre_m) done = 1;
      end else if (f && trig_n < 0 && n >= pre_m) begin
        pend = 1;
      end
      if (!a && trig_n < 0) active = 0;
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", wr_en, exp_wr_en);
    chk("wr_addr", wr_addr, exp_wr_addr);
    chk("wr_data", wr_data, exp_wr_data);
    chk("frame_ready", frame_ready, active && done);
    chk("busy", busy, active);
    chk("trig_addr", trig_addr, exp_trig_addr);
    chk("frame_start", frame_start, exp_frame_start);
  endtask

  task automatic tick(logic sv, logic [7:0] s, logic f, logic ack);
    sample_valid = sv; sample = s; force_trig = f; pi_ack = ack;
    @(posedge osc_clk);
    model_edge(arm, sv, s, f, ack);
    @(negedge osc_clk);
    sample_valid = 0; force_trig = 0; pi_ack = 0;
    check_outputs();
  endtask

  task automatic idle(int cnt);
    for (int i = 0; i < cnt; i++) tick(0, 8'h00, 0, 0);
  endtask

  task automatic smp(logic [7:0] s);
    tick(1, s, 0, 0);
    tick(0, 8'h00, 0, 0);
  endtask

  initial begin
    int steps, r;
    model_reset();
    #3 check_outputs();
    @(negedge osc_clk);
    reset = 1;

    // Rising ramp, pre_len 4: trigger on 0x80 at address 8.
    pre_len = 5'd4; trig_rising = 1; trig_level = 8'h80; arm = 1;
    tick(0, 8'h00, 0, 0); idle(2);
    for (int i = 0; i < 20; i++) begin
      smp(8'(i * 16));
      if (i == 8)  chk("ramp_trig_addr", trig_addr, 8);
      if (i == 18) chk("ramp_not_ready_early", frame_ready, 0);
    end
    chk("ramp_frame_ready", frame_ready, 1);
    chk("ramp_frame_start", frame_start, 4);

    // Samples in WAIT_PI are dropped; pi_ack with arm restarts at address 0.
    tick(1, 8'hAA, 0, 0);
    chk("waitpi_drop", wr_en, 0);
    tick(0, 8'h00, 0, 1'b0);
    pre_len = 5'd4; trig_rising = 0; trig_level = 8'h40;
    tick(0, 8'h00, 0, 1); idle(2);
    chk("reentry_not_ready", frame_ready, 0);
    smp(8'h20);
    chk("restart_addr0", wr_addr, 0);

    // Falling, constant below level: only force triggers.
    for (int i = 0; i < 9; i++) smp(8'h20);
    chk("const_no_trig", trig_addr, 8);
    tick(0, 8'h00, 1, 0);
    smp(8'h20);
    chk("force_trig_addr", trig_addr, 10);
    for (int i = 0; i < 10; i++) smp(8'h20);
    chk("force_not_ready_early", frame_ready, 0);
    smp(8'h20);
    chk("force_frame_ready", frame_ready, 1);
    chk("force_frame_start", frame_start, 6);
    arm = 0;
    tick(0, 8'h00, 0, 1);
    chk("ack_disarmed_idle", busy, 0);

    // pre_len 0: the first sample has no predecessor and cannot trigger.
    pre_len = 5'd0; trig_rising = 1; trig_level = 8'h80; arm = 1;
    tick(0, 8'h00, 0, 0); idle(2);
    smp(8'hFF);
    chk("first_sample_no_trig", trig_addr, 10);
    smp(8'hFF); smp(8'h10); smp(8'h90);
    chk("pre0_trig_addr", trig_addr, 3);
    for (int i = 0; i < 15; i++) smp(8'($urandom_range(0, 255)));
    chk("pre0_frame_ready", frame_ready, 1);

    // pre_len 15: trigger after wrap, frame done on the trigger sample itself.
    pre_len = 5'd15;
    tick(0, 8'h00, 0, 1); idle(2);
    for (int i = 0; i < 19; i++) smp(8'h10);
    smp(8'h90);
    chk("wrap_trig_addr", trig_addr, 3);
    chk("wrap_frame_start", frame_start, 4);
    chk("wrap_frame_ready", frame_ready, 1);

    // Asynchronous reset during POSTTRIG, then fresh capture with arm held.
    pre_len = 5'd4;
    tick(0, 8'h00, 0, 1); idle(2);
    for (int i = 0; i < 8; i++) smp(8'(i * 32));
    #2 reset = 0;
    #1 model_reset();
    check_outputs();
    chk("reset_busy", busy, 0);
    @(negedge osc_clk);
    reset = 1;
    tick(0, 8'h00, 0, 0); idle(2);
    chk("post_reset_busy", busy, 1);
    for (int i = 0; i < 24; i++) smp(8'(i * 16));
    chk("post_reset_frame", frame_ready, 1);

    // Random sessions; pre_len up to 20 exercises the clamp.
    for (int sess = 0; sess < 8; sess++) begin
      arm = 0;
      tick(0, 8'h00, 0, 1); idle(1);
      pre_len     = AW'($urandom_range(0, 20));
      trig_rising = 1'($urandom_range(0, 1));
      trig_level  = 8'($urandom_range(0, 255));
      arm = 1;
      tick(0, 8'h00, 0, 0); idle(2);
      steps = 0;
      while (!(active && done) && steps < 300) begin
        r = int'($urandom_range(0, 99));
        if (r < 60) smp(8'($urandom_range(0, 255)));
        else if (r < 70) tick(0, 8'h00, 1, 0);
        else if (r < 73 && trig_n < 0) begin
          arm = 0; tick(0, 8'h00, 0, 0);
          arm = 1; tick(0, 8'h00, 0, 0); idle(2);
        end else tick(0, 8'h00, 0, 0);
        steps++;
      end
      chk("rand_frame_ready", frame_ready, 1);
      smp(8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
